// File: rtl/pic_irq_ctrl.sv
// pic_irq_ctrl: parametrised 8259-style interrupt controller with IRR/ISR/IMR,
// fully nested fixed or rotating priority, edge/level triggering and auto-EOI.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   cs_i, wr_i, rd_i    register bus strobes (wr/rd qualified by cs)
//   a_i, din_i, dout_o  register address, write data, registered read data
//   ir_i                interrupt request lines (synchronous to clk_i)
//   int_o               registered interrupt request to the CPU
//   inta_i              one-cycle acknowledge from the CPU
//   vec_o, vec_valid_o  vector returned the cycle after inta_i
module pic_irq_ctrl #(
   parameter int NUM_IR = 8,
   parameter int DW     = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cs_i,
   input  logic              wr_i,
   input  logic              rd_i,
   input  logic [1:0]        a_i,
   input  logic [DW-1:0]     din_i,
   output logic [DW-1:0]     dout_o,
   input  logic [NUM_IR-1:0] ir_i,
   output logic              int_o,
   input  logic              inta_i,
   output logic [DW-1:0]     vec_o,
   output logic              vec_valid_o
);

   localparam int IDW = (NUM_IR > 1) ? $clog2(NUM_IR) : 1;

   // (l + 1) mod NUM_IR without a divider
   function automatic logic [IDW-1:0] nxt(input logic [IDW-1:0] l);
      if (int'(l) == NUM_IR - 1) return '0;
      return l + 1'b1;
   endfunction

   // Highest-priority set bit of v when level p ranks first: {found, level}
   function automatic logic [IDW:0] top(input logic [NUM_IR-1:0] v,
                                        input logic [IDW-1:0]    p);
      logic           f;
      logic [IDW-1:0] l;
      logic [IDW-1:0] r;
      f = 1'b0;
      r = '0;
      l = p;
      for (int k = 0; k < NUM_IR; k++) begin
         if (!f && v[l]) begin
            f = 1'b1;
            r = l;
         end
         l = nxt(l);
      end
      return {f, r};
   endfunction

   // Distance of level l from the top-priority level p (0 = highest)
   function automatic logic [IDW-1:0] rank(input logic [IDW-1:0] l,
                                           input logic [IDW-1:0] p);
      if (l >= p) return l - p;
      return IDW'(int'(l) + NUM_IR - int'(p));
   endfunction

   logic [2:0]        ctrl_q, ctrl_d;
   logic [DW-1:IDW]   base_q, base_d;
   logic [NUM_IR-1:0] imr_q, imr_d;
   logic [NUM_IR-1:0] irr_q, irr_d;
   logic [NUM_IR-1:0] isr_q, isr_d;
   logic [NUM_IR-1:0] ir_q;
   logic [IDW-1:0]    ptr_q, ptr_d;
   logic              int_q, int_d;
   logic [DW-1:0]     dout_q, dout_d;
   logic [DW-1:0]     vec_q, vec_d;
   logic              vv_q, vv_d;

   logic              ltim, aeoi, rot;
   logic [IDW-1:0]    pp;
   logic              win_f, isr_f;
   logic [IDW-1:0]    win_l, isr_l;
   logic              we, re, ack;
   logic [IDW-1:0]    eoi_l;

   assign ltim = ctrl_q[0];
   assign aeoi = ctrl_q[1];
   assign rot  = ctrl_q[2];
   assign pp   = rot ? ptr_q : '0;

   assign {win_f, win_l} = top(irr_q & ~imr_q, pp);
   assign {isr_f, isr_l} = top(isr_q, pp);

   assign we    = cs_i & wr_i;
   assign re    = cs_i & rd_i;
   assign ack   = inta_i & win_f;
   assign eoi_l = din_i[IDW-1:0];

   always_comb begin
      ctrl_d = ctrl_q;
      base_d = base_q;
      imr_d  = imr_q;
      irr_d  = irr_q;
      isr_d  = isr_q;
      ptr_d  = ptr_q;
      dout_d = dout_q;
      vec_d  = vec_q;
      vv_d   = 1'b0;

      // Full nesting: an in-service level of equal or higher rank blocks
      int_d = win_f & (~isr_f | (rank(win_l, pp) < rank(isr_l, pp)));

      if (re) begin
         unique case (a_i)
            2'd0: dout_d = DW'(ctrl_q);
            2'd1: dout_d = DW'(isr_q);
            2'd2: dout_d = DW'(imr_q);
            2'd3: dout_d = DW'(irr_q);
         endcase
      end

      if (ltim) begin
         irr_d = ir_i;
      end else begin
         if (ack) irr_d[win_l] = 1'b0;
         // a fresh edge overrides the acknowledge clear
         irr_d = irr_d | (ir_i & ~ir_q);
      end

      if (we && a_i == 2'd3) begin
         if (din_i[6]) begin
            if (|isr_q && int'(eoi_l) < NUM_IR) begin
               isr_d[eoi_l] = 1'b0;
               if (rot) ptr_d = nxt(eoi_l);
            end
         end else if (din_i[7] && isr_f) begin
            isr_d[isr_l] = 1'b0;
            if (rot) ptr_d = nxt(isr_l);
         end
      end

      // Acknowledge after EOI so a same-bit set wins
      if (ack) begin
         if (!aeoi) isr_d[win_l] = 1'b1;
         else if (rot) ptr_d = nxt(win_l);
      end

      if (inta_i) begin
         vv_d  = 1'b1;
         vec_d = {base_q, win_f ? win_l : IDW'(NUM_IR - 1)};
      end

      // Register writes last: a CTRL write clears state over everything
      if (we) begin
         unique case (a_i)
            2'd0: begin
               ctrl_d = din_i[2:0];
               irr_d  = '0;
               isr_d  = '0;
               ptr_d  = '0;
            end
            2'd1: base_d = din_i[DW-1:IDW];
            2'd2: imr_d  = din_i[NUM_IR-1:0];
            2'd3: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ctrl_q <= '0;
         base_q <= '0;
         imr_q  <= '0;
         irr_q  <= '0;
         isr_q  <= '0;
         ptr_q  <= '0;
         ir_q   <= '1;
         int_q  <= 1'b0;
         dout_q <= '0;
         vec_q  <= '0;
         vv_q   <= 1'b0;
      end else begin
         ctrl_q <= ctrl_d;
         base_q <= base_d;
         imr_q  <= imr_d;
         irr_q  <= irr_d;
         isr_q  <= isr_d;
         ptr_q  <= ptr_d;
         ir_q   <= ir_i;
         int_q  <= int_d;
         dout_q <= dout_d;
         vec_q  <= vec_d;
         vv_q   <= vv_d;
      end
   end

   assign dout_o      = dout_q;
   assign int_o       = int_q;
   assign vec_o       = vec_q;
   assign vec_valid_o = vv_q;

endmodule
